max_count_config: RTL and testbench

Button-driven editor for the counter's upper limit. Sits upstream of the increment stage and replaces its constant all-ones limit with a user-set 16-bit value. Takes the debounced push-button levels and lets the user edit the value one hex digit at a time. The committed value drives the increment stage's `maxCount` input; the in-progress value can be routed to the seven-segment display while editing.

---
 rtl/max_count_config.sv | 187 ++++++++++++++++++
 tb/tb_max_count_config.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/max_count_config.sv
`default_nettype none
// ============================================================================
//  Module      : max_count_config
//  Description : Push-button editor for the counter's 16-bit upper limit.
//                The user edits the value one hex digit at a time and commits
//                it; the committed value only changes on an accepted commit or
//                on reset, so downstream never sees a partial edit.
//                Optional feature macro: MAXCNT_AUTOREPEAT_EN (hold-to-repeat
//                on btnUp).
//  Revision    : 1.0 - initial release
// ============================================================================
module max_count_config #(
    parameter logic [15:0] RESET_MAX     = 16'hFFFF,
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btnMode,
    input  logic        btnNext,
    input  logic        btnUp,
    output logic [15:0] maxCount,
    output logic [15:0] editValue,
    output logic [1:0]  editDigit,
    output logic        editing,
    output logic        updated,
    output logic        rejected
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EDIT = 1'b1
    } state_t;

    // A zero hold or repeat period has no sensible meaning for auto-repeat.
    if (HOLD_CYCLES == 0 || REPEAT_CYCLES == 0) begin : g_paramCheck
        $error("max_count_config: HOLD_CYCLES and REPEAT_CYCLES must be non-zero");
    end

    state_t      r_state;
    state_t      w_stateNext;
    logic        r_modePrev;
    logic        r_nextPrev;
    logic        r_upPrev;
    logic [15:0] r_maxCount;
    logic [15:0] w_maxCountNext;
    logic [15:0] r_editValue;
    logic [15:0] w_editValueNext;
    logic [1:0]  r_editDigit;
    logic [1:0]  w_editDigitNext;
    logic        r_updated;
    logic        w_updatedNext;
    logic        r_rejected;
    logic        w_rejectedNext;
    logic        w_repeatStep;

    logic w_modeEdge;
    logic w_nextEdge;
    logic w_upEdge;

    assign w_modeEdge = btnMode & ~r_modePrev;
    assign w_nextEdge = btnNext & ~r_nextPrev;
    assign w_upEdge   = btnUp   & ~r_upPrev;

    // Increment one nibble modulo 16; neighbouring nibbles never see a carry.
    function automatic logic [15:0] incNibble(input logic [15:0] value, input logic [1:0] digit);
        logic [15:0] result;
        result = value;
        case (digit)
            2'd0:    result[3:0]   = value[3:0]   + 4'd1;
            2'd1:    result[7:4]   = value[7:4]   + 4'd1;
            2'd2:    result[11:8]  = value[11:8]  + 4'd1;
            default: result[15:12] = value[15:12] + 4'd1;
        endcase
        return result;
    endfunction

`ifdef MAXCNT_AUTOREPEAT_EN
    logic [31:0] r_repeatCnt;
    logic [31:0] w_repeatCntNext;
    logic        r_repeating;
    logic        w_repeatingNext;

    // Hold timer: counts cycles since the last step while btnUp stays high.
    // r_repeating selects the first (hold) or subsequent (repeat) period.
    always_comb begin
        w_repeatCntNext = 32'd0;
        w_repeatingNext = 1'b0;
        w_repeatStep    = 1'b0;
        if (r_state == ST_EDIT && btnUp && !w_modeEdge && !w_nextEdge) begin
            if (w_upEdge) begin
                w_repeatCntNext = 32'd1;
            end else if (r_repeatCnt != 32'd0) begin
                if (r_repeatCnt == (r_repeating ? REPEAT_CYCLES : HOLD_CYCLES)) begin
                    w_repeatStep    = 1'b1;
                    w_repeatCntNext = 32'd1;
                    w_repeatingNext = 1'b1;
                end else begin
                    w_repeatCntNext = r_repeatCnt + 32'd1;
                    w_repeatingNext = r_repeating;
                end
            end
        end
    end

    // Hold timer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_repeatCnt <= 32'd0;
            r_repeating <= 1'b0;
        end else begin
            r_repeatCnt <= w_repeatCntNext;
            r_repeating <= w_repeatingNext;
        end
    end
`else
    assign w_repeatStep = 1'b0;
`endif

    // Next-state and datapath decode; btnMode beats btnNext beats btnUp.
    always_comb begin
        w_stateNext     = r_state;
        w_maxCountNext  = r_maxCount;
        w_editValueNext = r_editValue;
        w_editDigitNext = r_editDigit;
        w_updatedNext   = 1'b0;
        w_rejectedNext  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_modeEdge) begin
                    w_stateNext     = ST_EDIT;
                    w_editValueNext = r_maxCount;
                    w_editDigitNext = 2'd3;
                end
            end
            default: begin
                if (w_modeEdge) begin
                    if (r_editValue != 16'd0) begin
                        w_maxCountNext = r_editValue;
                        w_updatedNext  = 1'b1;
                        w_stateNext    = ST_IDLE;
                    end else begin
                        w_rejectedNext = 1'b1;
                    end
                end else if (w_nextEdge) begin
                    w_editDigitNext = r_editDigit - 2'd1;
                end else if (w_upEdge || w_repeatStep) begin
                    w_editValueNext = incNibble(r_editValue, r_editDigit);
                end
            end
        endcase
    end

    // State, edge-detect history and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_modePrev  <= 1'b0;
            r_nextPrev  <= 1'b0;
            r_upPrev    <= 1'b0;
            r_maxCount  <= RESET_MAX;
            r_editValue <= RESET_MAX;
            r_editDigit <= 2'd3;
            r_updated   <= 1'b0;
            r_rejected  <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_modePrev  <= btnMode;
            r_nextPrev  <= btnNext;
            r_upPrev    <= btnUp;
            r_maxCount  <= w_maxCountNext;
            r_editValue <= w_editValueNext;
            r_editDigit <= w_editDigitNext;
            r_updated   <= w_updatedNext;
            r_rejected  <= w_rejectedNext;
        end
    end

    assign maxCount  = r_maxCount;
    assign editValue = r_editValue;
    assign editDigit = r_editDigit;
    assign editing   = (r_state == ST_EDIT);
    assign updated   = r_updated;
    assign rejected  = r_rejected;

endmodule
`default_nettype wire

// File: tb/tb_max_count_config.sv
`default_nettype none
// ============================================================================
//  Module      : tb_max_count_config
//  Description : Self-checking bench for max_count_config: directed scenarios
//                plus randomized button activity against a behavioural model.
//                Honours MAXCNT_AUTOREPEAT_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_max_count_config;

    localparam int HOLD   = 10;
    localparam int REPEAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btnMode = 1'b0;
    logic        btnNext = 1'b0;
    logic        btnUp = 1'b0;
    logic [15:0] maxCount;
    logic [15:0] editValue;
    logic [1:0]  editDigit;
    logic        editing;
    logic        updated;
    logic        rejected;

    max_count_config #(
        .RESET_MAX     (16'hFFFF),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REPEAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btnMode   (btnMode),
        .btnNext   (btnNext),
        .btnUp     (btnUp),
        .maxCount  (maxCount),
        .editValue (editValue),
        .editDigit (editDigit),
        .editing   (editing),
        .updated   (updated),
        .rejected  (rejected)
    );

    always #5 clk = ~clk;

    int vecCount = 0;
    int errCount = 0;

    // Reference model state, kept as plain integers.
    int  mMax, mVal, mDig, mRun;
    bit  mEditing, mUpd, mRej;
    bit  pM, pN, pU;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkOutputs();
        checkEq("maxCount",  32'(maxCount),  32'(mMax));
        checkEq("editValue", 32'(editValue), 32'(mVal));
        checkEq("editDigit", 32'(editDigit), 32'(mDig));
        checkEq("editing",   32'(editing),   32'(mEditing));
        checkEq("updated",   32'(updated),   32'(mUpd));
        checkEq("rejected",  32'(rejected),  32'(mRej));
    endtask

    task automatic modelReset();
        mMax = 16'hFFFF; mVal = 16'hFFFF; mDig = 3; mRun = -1;
        mEditing = 0; mUpd = 0; mRej = 0;
        pM = 0; pN = 0; pU = 0;
    endtask

    // One clock of the behavioural rules, given the levels sampled this edge.
    task automatic modelStep(input bit m, input bit n, input bit u);
        bit me, ne, ue, step;
        int nib;
        me = m && !pM; ne = n && !pN; ue = u && !pU;
        step = 0; mUpd = 0; mRej = 0;
        if (!mEditing) begin
            mRun = -1;
            if (me) begin mEditing = 1; mVal = mMax; mDig = 3; end
        end else if (me) begin
            mRun = -1;
            if (mVal != 0) begin mMax = mVal; mUpd = 1; mEditing = 0; end
            else mRej = 1;
        end else if (ne) begin
            mRun = -1;
            mDig = (mDig + 3) % 4;
        end else if (u) begin
            if (ue) begin
                mRun = 0; step = 1;
            end else if (mRun >= 0) begin
                mRun++;
`ifdef MAXCNT_AUTOREPEAT_EN
                if (mRun >= HOLD && ((mRun - HOLD) % REPEAT) == 0) step = 1;
`endif
            end
        end else begin
            mRun = -1;
        end
        if (step) begin
            nib  = ((mVal >> (4 * mDig)) + 1) % 16;
            mVal = (mVal & ~(15 << (4 * mDig)) & 16'hFFFF) | (nib << (4 * mDig));
        end
        pM = m; pN = n; pU = u;
    endtask

    // Apply levels, let one clock edge pass, then compare everything.
    task automatic cycle(input bit m, input bit n, input bit u);
        btnMode = m; btnNext = n; btnUp = u;
        @(posedge clk);
        modelStep(m, n, u);
        #1;
        checkOutputs();
    endtask

    task automatic press(input bit m, input bit n, input bit u, input int times);
        for (int i = 0; i < times; i++) begin
            cycle(m, n, u);
            cycle(0, 0, 0);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        #2;
        modelReset();
        checkOutputs();
        @(posedge clk);
        #1;
        checkOutputs();
        rst = 1'b0;
    endtask

    initial begin
        modelReset();
        @(posedge clk); #1;
        doReset();
        checkEq("rst_maxCount", 32'(maxCount), 32'h0000_FFFF);
        checkEq("rst_editing",  32'(editing),  32'd0);
        checkEq("rst_digit",    32'(editDigit), 32'd3);

        // Edit and commit: FFFF -> 1FF0.
        press(1, 0, 0, 1);
        press(0, 0, 1, 2);
        press(0, 1, 0, 3);
        press(0, 0, 1, 1);
        cycle(1, 0, 0);
        checkEq("commit_updated", 32'(updated), 32'd1);
        checkEq("commit_max",     32'(maxCount), 32'h0000_1FF0);
        cycle(0, 0, 0);
        checkEq("commit_pulse_end", 32'(updated), 32'd0);
        checkEq("commit_editing",   32'(editing), 32'd0);

        // Reach 1000, then try to commit zero.
        press(1, 0, 0, 1);
        press(0, 1, 0, 1); press(0, 0, 1, 1);
        press(0, 1, 0, 1); press(0, 0, 1, 1);
        press(1, 0, 0, 1);
        checkEq("setup_max", 32'(maxCount), 32'h0000_1000);
        press(1, 0, 0, 1);
        press(0, 0, 1, 15);
        checkEq("zero_value", 32'(editValue), 32'h0);
        cycle(1, 0, 0);
        checkEq("zero_rejected", 32'(rejected), 32'd1);
        checkEq("zero_max",      32'(maxCount), 32'h0000_1000);
        checkEq("zero_editing",  32'(editing),  32'd1);
        cycle(0, 0, 0);
        checkEq("zero_pulse_end", 32'(rejected), 32'd0);

        // Simultaneous next + up: only the digit moves.
        cycle(0, 1, 1);
        checkEq("simul_digit", 32'(editDigit), 32'd2);
        checkEq("simul_value", 32'(editValue), 32'h0);
        cycle(0, 0, 0);

        // Reset mid-edit at 2345.
        doReset();
        press(1, 0, 0, 1);
        press(0, 0, 1, 3); press(0, 1, 0, 1);
        press(0, 0, 1, 4); press(0, 1, 0, 1);
        press(0, 0, 1, 5); press(0, 1, 0, 1);
        press(0, 0, 1, 6);
        checkEq("mid_value", 32'(editValue), 32'h0000_2345);
        doReset();
        checkEq("mid_rst_max",   32'(maxCount),  32'h0000_FFFF);
        checkEq("mid_rst_value", 32'(editValue), 32'h0000_FFFF);
        checkEq("mid_rst_edit",  32'(editing),   32'd0);

        // Hold btnUp for 20 cycles from 0FFF on digit 3.
        press(1, 0, 0, 1);
        press(0, 0, 1, 1);
        for (int i = 0; i < 20; i++) cycle(0, 0, 1);
        cycle(0, 0, 0);
`ifdef MAXCNT_AUTOREPEAT_EN
        checkEq("hold_value", 32'(editValue), 32'h0000_4FFF);
`else
        checkEq("hold_value", 32'(editValue), 32'h0000_1FFF);
`endif

        // Button held through reset yields an edge right after release.
        btnMode = 1'b1;
        doReset();
        cycle(1, 0, 0);
        checkEq("held_rst_editing", 32'(editing), 32'd1);
        cycle(0, 0, 0);

        // Randomized sticky button levels with occasional resets.
        begin
            bit m, n, u;
            m = 0; n = 0; u = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 99) < 12) m = ~m;
                if ($urandom_range(0, 99) < 20) n = ~n;
                if ($urandom_range(0, 99) < 25) u = ~u;
                if ($urandom_range(0, 999) < 3) begin
                    btnMode = m; btnNext = n; btnUp = u;
                    doReset();
                end else begin
                    cycle(m, n, u);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
`default_nettype wire
